// File: rtl/dice_roller_pkg.sv
// Shared definitions for the dice roller: face encoding, FSM states and
// the face-counter step function.
package dice_roller_pkg;

    localparam logic [3:0] FACE_NONE = 4'd0;
    localparam logic [2:0] FACE_MIN  = 3'd1;
    localparam logic [2:0] FACE_MAX  = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        PRESENT = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_e;

    // Next face in the 1..6 cycle; 0 and 7 are never produced.
    function automatic logic [2:0] face_next(input logic [2:0] face);
        logic [2:0] nxt;
        if (face >= FACE_MAX) begin
            nxt = FACE_MIN;
        end else begin
            nxt = face + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dice_channel.sv
// One player's channel: key synchronizer, debouncer, free-running face
// counter, animation divider and the lock register for the current round.
module dice_channel
    import dice_roller_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int ANIM_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_i,
    input  logic       arm_i,
    input  logic       clr_lock_i,
    output logic       start_o,
    output logic       press_o,
    output logic       rolling_o,
    output logic       locked_o,
    output logic [3:0] dice_o
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int ANIM_W = $clog2(ANIM_CYCLES + 1);

    logic [1:0]        sync_q;
    logic              deb_q, deb_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [2:0]        face_q, face_d;
    logic [ANIM_W-1:0] anim_q, anim_d;
    logic [3:0]        dice_q, dice_d;
    logic              rolling_q, rolling_d;
    logic              locked_q, locked_d;
    logic              armed_s, press_s, release_s;

    // Debounce, roll start (rising edge only, so a held key cannot re-roll),
    // animation refresh and lock capture on the debounced release.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        face_d    = face_q;
        anim_d    = anim_q;
        dice_d    = dice_q;
        rolling_d = rolling_q;
        locked_d  = locked_q;
        armed_s   = arm_i & ~locked_q;

        if (sync_q[1] != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                deb_d     = ~deb_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end

        press_s   = armed_s & ~deb_q & deb_d;
        release_s = rolling_q & deb_q & ~deb_d;

        if (press_s) begin
            rolling_d = 1'b1;
            face_d    = FACE_MIN;
            anim_d    = '0;
        end else if (release_s) begin
            dice_d    = {1'b0, face_q};
            locked_d  = 1'b1;
            rolling_d = 1'b0;
        end else if (rolling_q) begin
            face_d = face_next(face_q);
            if (anim_q == ANIM_W'(ANIM_CYCLES - 1)) begin
                dice_d = {1'b0, face_q};
                anim_d = '0;
            end else begin
                anim_d = anim_q + ANIM_W'(1);
            end
        end else begin
            face_d = face_q;
        end

        if (clr_lock_i) begin
            locked_d = 1'b0;
        end else begin
            locked_d = locked_d;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b00;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            face_q    <= FACE_MIN;
            anim_q    <= '0;
            dice_q    <= FACE_NONE;
            rolling_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            face_q    <= face_d;
            anim_q    <= anim_d;
            dice_q    <= dice_d;
            rolling_q <= rolling_d;
            locked_q  <= locked_d;
        end
    end

    assign start_o   = deb_q & armed_s;
    assign press_o   = press_s;
    assign rolling_o = rolling_q;
    assign locked_o  = locked_q;
    assign dice_o    = dice_q;

endmodule

// File: rtl/dice_roller.sv
// Dice roller top: two player channels plus the round FSM that presents
// the locked pair to the scoring block and waits for it before re-arming.
module dice_roller
    import dice_roller_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int ANIM_CYCLES = 5000000,
    parameter int BUSY_TMO    = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1,
    input  logic       key2,
    input  logic       score_busy,
    output logic       start1,
    output logic       start2,
    output logic [3:0] dice1,
    output logic [3:0] dice2,
    output logic       rolling1,
    output logic       rolling2,
    output logic       locked1,
    output logic       locked2,
    output logic       roll_valid
);

    localparam int TMO_W = $clog2(BUSY_TMO + 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             roll_valid_q;
    logic             arm_s, clr_lock_s;
    logic             press1_s, press2_s;

    assign arm_s = (state_q == IDLE) || (state_q == COLLECT);

    dice_channel #(.DEB_CYCLES(DEB_CYCLES), .ANIM_CYCLES(ANIM_CYCLES)) u_ch1 (
        .clk(clk), .rst(rst), .key_i(key1), .arm_i(arm_s), .clr_lock_i(clr_lock_s),
        .start_o(start1), .press_o(press1_s), .rolling_o(rolling1),
        .locked_o(locked1), .dice_o(dice1)
    );

    dice_channel #(.DEB_CYCLES(DEB_CYCLES), .ANIM_CYCLES(ANIM_CYCLES)) u_ch2 (
        .clk(clk), .rst(rst), .key_i(key2), .arm_i(arm_s), .clr_lock_i(clr_lock_s),
        .start_o(start2), .press_o(press2_s), .rolling_o(rolling2),
        .locked_o(locked2), .dice_o(dice2)
    );

    // Round sequencing; tmo counts cycles elapsed since PRESENT.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        clr_lock_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (press1_s || press2_s) begin
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (locked1 && locked2 && !score_busy) begin
                    state_d = PRESENT;
                end else begin
                    state_d = COLLECT;
                end
            end
            PRESENT: begin
                state_d = WAIT_HI;
                tmo_d   = TMO_W'(1);
            end
            WAIT_HI: begin
                if (score_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TMO_W'(BUSY_TMO - 1)) begin
                    state_d    = IDLE;
                    clr_lock_s = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!score_busy) begin
                    state_d    = IDLE;
                    clr_lock_s = 1'b1;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, timeout counter and registered valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            roll_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            roll_valid_q <= (state_d == PRESENT);
        end
    end

    assign roll_valid = roll_valid_q;

endmodule

// File: tb/tb_dice_roller.sv
// Randomized scoreboard bench for dice_roller (DEB=4, ANIM=8, TMO=16).
module tb_dice_roller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key1 = 1'b0, key2 = 1'b0, score_busy = 1'b0;
    logic       start1, start2, rolling1, rolling2, locked1, locked2, roll_valid;
    logic [3:0] dice1, dice2;

    typedef struct {
        int d1;
        int d2;
        bit simul;
    } exp_t;

    exp_t exp_q[$];
    exp_t ex;
    int   checks = 0, failures = 0;
    int   cyc = 0, rv_cnt = 0, rv_cyc = 0, l1_cyc = 0, l2_cyc = 0, hs_cyc = 0;
    int   last_d1 = 0, last_d2 = 0;
    bit   l1_prev = 1'b0, l2_prev = 1'b0;

    dice_roller #(.DEB_CYCLES(4), .ANIM_CYCLES(8), .BUSY_TMO(16)) dut (
        .clk(clk), .rst(rst), .key1(key1), .key2(key2), .score_busy(score_busy),
        .start1(start1), .start2(start2), .dice1(dice1), .dice2(dice2),
        .rolling1(rolling1), .rolling2(rolling2), .locked1(locked1),
        .locked2(locked2), .roll_valid(roll_valid)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Face after holding a key for 'held' debounced cycles, counting from 1.
    function automatic int face_of(input int held);
        return ((held - 1) % 6) + 1;
    endfunction

    // Monitor: pops an expected pair whenever roll_valid is presented.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            l1_prev = 1'b0;
            l2_prev = 1'b0;
        end else begin
            if (locked1 && !l1_prev) l1_cyc = cyc;
            if (locked2 && !l2_prev) l2_cyc = cyc;
            l1_prev = locked1;
            l2_prev = locked2;
            if (roll_valid) begin
                rv_cnt++;
                rv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("rv_unexpected", 1, 0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("dice1_pair", int'(dice1), ex.d1);
                    chk("dice2_pair", int'(dice2), ex.d2);
                    chk("rv_latency", cyc, ((l1_cyc > l2_cyc) ? l1_cyc : l2_cyc) + 1);
                    if (ex.simul) chk("simul_lock", l1_cyc, l2_cyc);
                end
            end
        end
    end

    task automatic set_key(input int which, input logic v);
        if (which == 1) key1 = v;
        else key2 = v;
    endtask

    task automatic drive_key(input int which, input int dly, input int hold, input bit bounce);
        repeat (dly) @(negedge clk);
        if (bounce) begin
            for (int i = 0; i < 2; i++) begin
                set_key(which, 1'b1);
                repeat (2) @(negedge clk);
                set_key(which, 1'b0);
                repeat (2) @(negedge clk);
            end
        end
        set_key(which, 1'b1);
        if (which == 1) hs_cyc = cyc;
        repeat (hold) @(negedge clk);
        set_key(which, 1'b0);
    endtask

    // Debounce latency after bouncing, and first animation update timing.
    task automatic anim_probe();
        int t0;
        for (int i = 0; i < 80 && !start1; i++) @(negedge clk);
        t0 = cyc;
        chk("deb_rise_cycle", t0, hs_cyc + 6);
        repeat (7) @(negedge clk);
        chk("anim_hold", int'(dice1), last_d1);
        @(negedge clk);
        chk("anim_first", int'(dice1), 2);
    endtask

    task automatic run_round(input int d1, input int h1, input bit b1,
                             input int d2, input int h2,
                             input bit tmo_mode, input bit hold_across);
        exp_t e;
        int   base, viol;
        e.d1    = face_of(h1);
        e.d2    = face_of(h2);
        e.simul = ((d1 + (b1 ? 8 : 0) + h1) == (d2 + h2));
        exp_q.push_back(e);
        base = rv_cnt;
        fork
            drive_key(1, d1, h1, b1);
            drive_key(2, d2, h2, 1'b0);
            if (b1) anim_probe();
        join
        for (int i = 0; i < 60 && rv_cnt == base; i++) @(negedge clk);
        chk("rv_count", rv_cnt - base, 1);
        if (rv_cnt == base) begin
            exp_q.delete();
            return;
        end
        last_d1 = e.d1;
        last_d2 = e.d2;
        if (tmo_mode) begin
            while (cyc < rv_cyc + 15) @(negedge clk);
            chk("tmo_locks_held", int'(locked1 & locked2), 1);
            @(negedge clk);
            chk("tmo_lock1_clr", int'(locked1), 0);
            chk("tmo_lock2_clr", int'(locked2), 0);
            chk("tmo_dice1_kept", int'(dice1), e.d1);
            chk("tmo_dice2_kept", int'(dice2), e.d2);
        end else begin
            @(negedge clk);
            score_busy = 1'b1;
            viol = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (i == 2) key1 = 1'b1;
                if (i == 10 && !hold_across) key1 = 1'b0;
                if (start1 || rolling1 || start2 || rolling2) viol++;
            end
            chk("busy_ignore", viol, 0);
            chk("busy_locks_held", int'(locked1 & locked2), 1);
            score_busy = 1'b0;
            @(negedge clk);
            chk("busy_lock1_clr", int'(locked1), 0);
            chk("busy_lock2_clr", int'(locked2), 0);
            chk("busy_dice1_kept", int'(dice1), e.d1);
            if (hold_across) begin
                repeat (10) @(negedge clk);
                chk("held_no_roll", int'(rolling1), 0);
                chk("held_start_lvl", int'(start1), 1);
                key1 = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int base, d1, h1, d2, h2;
        repeat (3) @(negedge clk);
        chk("rst_dice1", int'(dice1), 0);
        chk("rst_dice2", int'(dice2), 0);
        chk("rst_flags", int'({start1, start2, rolling1, rolling2, locked1, locked2, roll_valid}), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Bounced key1 held 20 (face 2), key2 held 9 (face 3), busy handshake.
        run_round(0, 20, 1'b1, 3, 9, 1'b0, 1'b0);
        // Simultaneous release (faces 3 and 6), scorer never answers.
        run_round(2, 15, 1'b0, 5, 12, 1'b1, 1'b0);
        // Key held across re-arm.
        run_round(1, 11, 1'b0, 4, 7, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            d1 = int'($urandom_range(0, 8));
            h1 = int'($urandom_range(6, 36));
            d2 = int'($urandom_range(0, 8));
            h2 = int'($urandom_range(6, 36));
            if ($urandom_range(0, 3) == 0 && d1 + h1 >= h2) d2 = d1 + h1 - h2;
            run_round(d1, h1, 1'b0, d2, h2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a round.
        base = rv_cnt;
        key1 = 1'b1;
        for (int i = 0; i < 20 && !rolling1; i++) @(negedge clk);
        chk("pre_rst_rolling", int'(rolling1), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_dice1", int'(dice1), 0);
        chk("mid_rst_dice2", int'(dice2), 0);
        chk("mid_rst_flags", int'({start1, start2, rolling1, rolling2, locked1, locked2, roll_valid}), 0);
        key1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_dice1", int'(dice1), 0);
        chk("post_rst_rolling", int'(rolling1), 0);
        chk("post_rst_no_rv", rv_cnt - base, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
